gate_seq_ctrl: RTL and testbench
================================

Name: gate_seq_ctrl

Overview:
- Lane controller that sits in front of the occupancy counter datapath.
- Decodes the order in which two beam sensors trip (outer sa, inner sb) to tell a vehicle entering from one leaving.
- Drives the gate, refuses entry when the lot is full, and emits single-cycle cor_enter / cor_exit pulses to the counter.
- Aborted or stalled passages produce no count pulse.

Parameters:
- CNT_W, 4, width of the occupancy count input (matches the counter datapath).
- CAPACITY, 15, occupancy at which entry is denied; must be <= 2**CNT_W-1.
- TIMEOUT, 1000, cycles without sensor progress before a passage is abandoned.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- sa  in  1  outer beam sensor, 1 = beam blocked.
- sb  in  1  inner beam sensor, 1 = beam blocked.
- occ_cnt  in  CNT_W  current occupancy from the counter datapath.
- cor_enter  out  1  one-cycle pulse: a completed entry, counter increments.
- cor_exit  out  1  one-cycle pulse: a completed exit, counter decrements.
- gate_open  out  1  gate actuator, 1 = open.
- full  out  1  high while occ_cnt >= CAPACITY.
- err  out  1  sticky fault flag, cleared only by reset.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, timer=0.
  - cor_enter, cor_exit, gate_open and err all 0.
  - full is combinational from occ_cnt and is not reset.
- All outputs except full are registered.
- A pulse appears the cycle after the FSM samples the completing sensor value.
- State transitions (s = {sa,sb}):
  - IDLE: s=10 and occ_cnt<CAPACITY goes to IN_A. s=10 and full goes to DENY. s=01 goes to OUT_B. s=11 is ambiguous: stay in IDLE and set err.
  - IN_A: 11 goes to IN_AB; 00 goes to IDLE (backed away, no pulse).
  - IN_AB: 01 goes to IN_B; 10 goes to IN_A.
  - IN_B: 00 goes to IDLE and asserts cor_enter next cycle; 11 goes to IN_AB.
  - OUT_B: 11 goes to OUT_BA; 00 goes to IDLE with no pulse.
  - OUT_BA: 10 goes to OUT_A; 01 goes to OUT_B.
  - OUT_A: 00 goes to IDLE and asserts cor_exit next cycle, unless occ_cnt==0. If occ_cnt==0, no pulse and set err (underflow guard). 11 goes to OUT_BA.
  - DENY: gate stays closed; return to IDLE when s=00. A car sitting on sa does not re-evaluate fullness until it clears.
  - Any sensor value not listed for a state holds that state.
- gate_open is 1 in IN_A, IN_AB, IN_B, OUT_B, OUT_BA and OUT_A, and 0 in IDLE and DENY.
- Timeout:
  - timer resets to 0 on every state change and increments each cycle in a non-IDLE state.
  - When timer reaches TIMEOUT-1: set err, move to DENY, close the gate, and issue no pulse.
  - Timer width is $clog2(TIMEOUT+1); it saturates and never wraps.
- cor_enter and cor_exit are never high in the same cycle. Each lasts exactly one cycle.
- Reset mid-passage: return to IDLE and drop any pending pulse; the counter is not touched.

Optional Feature:
- Macro: GATE_SENSOR_SYNC_EN.
- Defined:
  - sa and sb each pass through a 2-flop synchronizer before the FSM.
  - All sensor-to-output latencies grow by 2 cycles.
  - The synchronizer flops reset to 0.
- Undefined: sa and sb feed the FSM directly; inputs must already be synchronous to clk.

Decomposition:
- Package gate_pkg holds:
  - the state enum (IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, DENY, 3-bit encoding);
  - sensor code constants S_CLR=2'b00, S_A=2'b10, S_B=2'b01, S_AB=2'b11.
- One sub-module, gate_sensor_sync: the 2-flop synchronizer, instantiated per sensor only under GATE_SENSOR_SYNC_EN.
- FSM, timer and output registers stay in gate_seq_ctrl.

Test Plan:
- Entry, occ_cnt=3: s = 10, 11, 01, 00, each held 2 cycles.
  - gate_open=1 from the cycle after s=10.
  - One cor_enter pulse the cycle after s=00.
  - gate_open=0 the cycle after s=00.
- Exit, occ_cnt=5: s = 01, 11, 10, 00.
  - Exactly one cor_exit pulse; cor_enter stays 0 throughout.
- Full: occ_cnt=15, s=10 for 5 cycles, then 00.
  - full=1; state reaches DENY.
  - gate_open stays 0; no pulses; return to IDLE.
- Abort: s = 10, 11, 10, 00.
  - Return to IDLE with no pulse; err=0.
- Timeout, TIMEOUT=8: s=11 held after IN_AB.
  - err=1 after 8 cycles; gate_open=0; no pulse.
  - Reset (reset=0 for 1 cycle) clears err.
- Underflow: occ_cnt=0 with a full exit sequence.
  - No cor_exit; err=1.
- Reset mid-entry: reset=0 while in IN_B.
  - Next cycle all outputs are 0.
  - A following s=00 produces no cor_enter.

Source files
------------

// File: rtl/gate_pkg.sv
// gate_pkg: shared FSM state encoding, sensor codes and gate decode for the lane controller.
//   Types : state_t (3-bit) IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, DENY
//   Consts: S_CLR, S_A, S_B, S_AB as {sa,sb} sensor codes
//   Func  : gate_is_open(state) -> 1 when the gate should be open in that state
package gate_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      IN_A   = 3'd1,
      IN_AB  = 3'd2,
      IN_B   = 3'd3,
      OUT_B  = 3'd4,
      OUT_BA = 3'd5,
      OUT_A  = 3'd6,
      DENY   = 3'd7
   } state_t;
   localparam logic [1:0] S_CLR = 2'b00;
   localparam logic [1:0] S_A   = 2'b10;
   localparam logic [1:0] S_B   = 2'b01;
   localparam logic [1:0] S_AB  = 2'b11;
   function automatic logic gate_is_open(input state_t st);
      return !(st == IDLE || st == DENY);
   endfunction
endpackage

// File: rtl/gate_sensor_sync.sv
// gate_sensor_sync: 2-flop synchronizer for one beam sensor.
//   clk   in  system clock
//   reset in  synchronous active-low reset, both flops clear to 0
//   d     in  asynchronous sensor level
//   q     out sensor level synchronous to clk (2-cycle latency)
module gate_sensor_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clk)
      if (!reset) {q, meta} <= 2'b00;
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/gate_seq_ctrl.sv
// gate_seq_ctrl: lane controller decoding beam-sensor order into entry/exit count pulses and gate control.
//   clk       in  system clock, rising edge
//   reset     in  synchronous active-low reset
//   sa, sb    in  outer / inner beam sensors, 1 = blocked
//   occ_cnt   in  current occupancy from the counter datapath
//   cor_enter out one-cycle pulse per completed entry
//   cor_exit  out one-cycle pulse per completed exit
//   gate_open out gate actuator, 1 = open
//   full      out occ_cnt >= CAPACITY (combinational, not reset)
//   err       out sticky fault flag, cleared only by reset
//   Build option: define GATE_SENSOR_SYNC_EN to insert 2-flop synchronizers on sa/sb
//   (adds 2 cycles to every sensor-to-output latency).
module gate_seq_ctrl
   import gate_pkg::*;
#(
   parameter int CNT_W    = 4,
   parameter int CAPACITY = 15,
   parameter int TIMEOUT  = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sa,
   input  logic             sb,
   input  logic [CNT_W-1:0] occ_cnt,
   output logic             cor_enter,
   output logic             cor_exit,
   output logic             gate_open,
   output logic             full,
   output logic             err
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
   state_t state, nxt;
   logic [TW-1:0] timer;
   logic [1:0] s;
   logic tmo;
`ifdef GATE_SENSOR_SYNC_EN
   logic sa_q, sb_q;
   gate_sensor_sync u_sync_a (.clk(clk), .reset(reset), .d(sa), .q(sa_q));
   gate_sensor_sync u_sync_b (.clk(clk), .reset(reset), .d(sb), .q(sb_q));
   assign s = {sa_q, sb_q};
`else
   assign s = {sa, sb};
`endif
   assign full = occ_cnt >= CAP;
   assign tmo = state != IDLE && timer == T_LAST;
   // a stalled passage overrides any sensor-driven move and parks in DENY
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = (s == S_A) ? (full ? DENY : IN_A) : (s == S_B) ? OUT_B : IDLE;
         IN_A:    nxt = (s == S_AB) ? IN_AB : (s == S_CLR) ? IDLE : IN_A;
         IN_AB:   nxt = (s == S_B) ? IN_B : (s == S_A) ? IN_A : IN_AB;
         IN_B:    nxt = (s == S_CLR) ? IDLE : (s == S_AB) ? IN_AB : IN_B;
         OUT_B:   nxt = (s == S_AB) ? OUT_BA : (s == S_CLR) ? IDLE : OUT_B;
         OUT_BA:  nxt = (s == S_A) ? OUT_A : (s == S_B) ? OUT_B : OUT_BA;
         OUT_A:   nxt = (s == S_CLR) ? IDLE : (s == S_AB) ? OUT_BA : OUT_A;
         DENY:    nxt = (s == S_CLR) ? IDLE : DENY;
         default: nxt = IDLE;
      endcase
      if (tmo) nxt = DENY;
   end
   always_ff @(posedge clk)
      if (!reset) begin
         state     <= IDLE;
         timer     <= '0;
         cor_enter <= 1'b0;
         cor_exit  <= 1'b0;
         gate_open <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= nxt;
         // timeout re-entering DENY is not a state change, so the timer saturates instead of restarting
         timer     <= (nxt != state) ? '0 : (state != IDLE && timer != T_MAX) ? timer + 1'b1 : timer;
         cor_enter <= state == IN_B && s == S_CLR && !tmo;
         cor_exit  <= state == OUT_A && s == S_CLR && occ_cnt != '0 && !tmo;
         gate_open <= gate_is_open(nxt);
         err       <= err | tmo | (state == IDLE && s == S_AB) | (state == OUT_A && s == S_CLR && occ_cnt == '0);
      end
endmodule

// File: tb/tb_gate_seq_ctrl.sv
// tb_gate_seq_ctrl: directed scoreboard bench for gate_seq_ctrl (TIMEOUT=8, default build).
module tb_gate_seq_ctrl;
   import gate_pkg::*;
   logic clk = 1'b0, reset = 1'b0, sa = 1'b0, sb = 1'b0;
   logic [3:0] occ_cnt = 4'd3;
   logic cor_enter, cor_exit, gate_open, full, err;
   logic [4:0] q[$];
   logic [4:0] exp_v, got_v;
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   gate_seq_ctrl #(.CNT_W(4), .CAPACITY(15), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .sa(sa), .sb(sb), .occ_cnt(occ_cnt),
      .cor_enter(cor_enter), .cor_exit(cor_exit), .gate_open(gate_open),
      .full(full), .err(err)
   );
   // drive one cycle of stimulus; exp = {cor_enter, cor_exit, gate_open, err} after the next edge
   task automatic step(input logic r, input logic [1:0] s, input logic [3:0] occ, input logic [3:0] exp);
      @(negedge clk);
      #1;
      reset = r;
      {sa, sb} = s;
      occ_cnt = occ;
      q.push_back({exp[3:1], occ >= 4'd15, exp[0]});
   endtask
   // monitor: each pushed expectation is compared one negedge after the edge it describes
   always @(negedge clk)
      if (q.size() != 0) begin
         exp_v = q.pop_front();
         got_v = {cor_enter, cor_exit, gate_open, full, err};
         tests++;
         if (got_v !== exp_v) begin
            fails++;
            $display("FAIL check %0d: {enter,exit,gate,full,err} got %b expected %b", tests, got_v, exp_v);
         end
      end
   initial begin
      step(1'b0, S_CLR, 4'd3, 4'b0000);
      // entry, each code held two cycles
      repeat (2) step(1'b1, S_A, 4'd3, 4'b0010);
      repeat (2) step(1'b1, S_AB, 4'd3, 4'b0010);
      repeat (2) step(1'b1, S_B, 4'd3, 4'b0010);
      step(1'b1, S_CLR, 4'd3, 4'b1000);
      step(1'b1, S_CLR, 4'd3, 4'b0000);
      // exit
      step(1'b1, S_B, 4'd5, 4'b0010);
      step(1'b1, S_AB, 4'd5, 4'b0010);
      step(1'b1, S_A, 4'd5, 4'b0010);
      step(1'b1, S_CLR, 4'd5, 4'b0100);
      step(1'b1, S_CLR, 4'd5, 4'b0000);
      // full lot: deny, gate stays shut
      repeat (5) step(1'b1, S_A, 4'd15, 4'b0000);
      step(1'b1, S_CLR, 4'd15, 4'b0000);
      step(1'b1, S_CLR, 4'd3, 4'b0000);
      // abort: backs out
      step(1'b1, S_A, 4'd3, 4'b0010);
      step(1'b1, S_AB, 4'd3, 4'b0010);
      step(1'b1, S_A, 4'd3, 4'b0010);
      step(1'b1, S_CLR, 4'd3, 4'b0000);
      step(1'b1, S_CLR, 4'd3, 4'b0000);
      // timeout: stalled in IN_AB
      step(1'b1, S_A, 4'd3, 4'b0010);
      repeat (8) step(1'b1, S_AB, 4'd3, 4'b0010);
      step(1'b1, S_AB, 4'd3, 4'b0001);
      step(1'b1, S_AB, 4'd3, 4'b0001);
      step(1'b1, S_CLR, 4'd3, 4'b0001);
      step(1'b0, S_CLR, 4'd3, 4'b0000);
      step(1'b1, S_CLR, 4'd3, 4'b0000);
      // ambiguous both-blocked in IDLE
      step(1'b1, S_AB, 4'd3, 4'b0001);
      step(1'b1, S_CLR, 4'd3, 4'b0001);
      step(1'b0, S_CLR, 4'd3, 4'b0000);
      // underflow guard
      step(1'b1, S_B, 4'd0, 4'b0010);
      step(1'b1, S_AB, 4'd0, 4'b0010);
      step(1'b1, S_A, 4'd0, 4'b0010);
      step(1'b1, S_CLR, 4'd0, 4'b0001);
      step(1'b1, S_CLR, 4'd0, 4'b0001);
      step(1'b0, S_CLR, 4'd0, 4'b0000);
      // reset mid-entry drops the pending pulse
      step(1'b1, S_A, 4'd3, 4'b0010);
      step(1'b1, S_AB, 4'd3, 4'b0010);
      step(1'b1, S_B, 4'd3, 4'b0010);
      step(1'b0, S_CLR, 4'd3, 4'b0000);
      step(1'b1, S_CLR, 4'd3, 4'b0000);
      step(1'b1, S_CLR, 4'd3, 4'b0000);
      repeat (3) @(negedge clk);
      #2;
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
